// File: rtl/feature_scaler_fx_if.sv
`default_nettype none
// ============================================================================
// Module   : feature_scaler_fx_if
// Purpose  : Stream, coefficient-write and status bundle for feature_scaler_fx.
// Revision : 1.0
// ============================================================================
interface feature_scaler_fx_if #(
    parameter int DATA_W = 16,
    parameter int COEF_W = 16,
    parameter int IDX_W  = 6
);
    logic                     s_valid;
    logic                     s_ready;
    logic signed [DATA_W-1:0] s_data;
    logic                     s_last;

    logic                     m_valid;
    logic                     m_ready;
    logic signed [DATA_W-1:0] m_data;
    logic                     m_last;
    logic        [IDX_W-1:0]  m_index;

    logic                     cfg_we;
    logic                     cfg_sel;
    logic        [IDX_W-1:0]  cfg_addr;
    logic signed [COEF_W-1:0] cfg_data;

    logic                     bypass;
    logic                     err_len;

    modport master (
        output s_valid, s_data, s_last, m_ready,
        output cfg_we, cfg_sel, cfg_addr, cfg_data, bypass,
        input  s_ready, m_valid, m_data, m_last, m_index, err_len
    );

    modport slave (
        input  s_valid, s_data, s_last, m_ready,
        input  cfg_we, cfg_sel, cfg_addr, cfg_data, bypass,
        output s_ready, m_valid, m_data, m_last, m_index, err_len
    );
endinterface
`default_nettype wire

// File: rtl/feature_scaler_fx.sv
`default_nettype none
// ============================================================================
// Module   : feature_scaler_fx
// Purpose  : Per-feature (x - mean) * inv_std normaliser, 3-stage stream pipe.
// Revision : 1.0
// ============================================================================
module feature_scaler_fx #(
    parameter int DATA_W    = 16,
    parameter int COEF_W    = 16,
    parameter int FRAC_BITS = 12,
    parameter int NUM_FEAT  = 39,
    parameter int IDX_W     = 6
) (
    input  wire logic          clk,
    input  wire logic          reset,
    feature_scaler_fx_if.slave bus
);
    localparam int c_diff_w = ((DATA_W > COEF_W) ? DATA_W : COEF_W) + 1;
    localparam int c_prod_w = c_diff_w + COEF_W;
    localparam logic signed [COEF_W-1:0] c_unity    = COEF_W'(2 ** FRAC_BITS);
    localparam logic signed [c_prod_w:0] c_half     = (c_prod_w + 1)'(2 ** (FRAC_BITS - 1));
    localparam logic signed [c_prod_w:0] c_max      = (c_prod_w + 1)'(2 ** (DATA_W - 1) - 1);
    localparam logic signed [c_prod_w:0] c_min      = ~c_max;
    localparam logic        [IDX_W:0]    c_num      = (IDX_W + 1)'(NUM_FEAT);
    localparam logic        [IDX_W-1:0]  c_last_idx = IDX_W'(NUM_FEAT - 1);

    logic signed [COEF_W-1:0] r_mean [NUM_FEAT];
    logic signed [COEF_W-1:0] r_inv  [NUM_FEAT];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_FEAT; i++) begin
                r_mean[i] <= '0;
                r_inv[i]  <= c_unity;
            end
        end else if (bus.cfg_we && ({1'b0, bus.cfg_addr} < c_num)) begin
            if (bus.cfg_sel) r_inv[bus.cfg_addr]  <= bus.cfg_data;
            else             r_mean[bus.cfg_addr] <= bus.cfg_data;
        end
    end

    // One enable advances every stage, so a stall freezes the whole pipe.
    logic w_en, w_accept, w_len_err;
    logic [IDX_W-1:0] r_idx;
    logic             r_err;

    assign w_en        = !bus.m_valid || bus.m_ready;
    assign w_accept    = bus.s_valid && w_en;
    assign w_len_err   = bus.s_last ^ (r_idx == c_last_idx);
    assign bus.s_ready = w_en;
    assign bus.err_len = r_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_idx <= '0;
            r_err <= 1'b0;
        end else begin
            r_err <= w_accept && w_len_err;
            if (w_accept) begin
                if (bus.s_last || (r_idx == c_last_idx)) r_idx <= '0;
                else                                     r_idx <= r_idx + 1'b1;
            end
        end
    end

    // Stage 1: subtract mean; inv_std is captured now so a same-cycle cfg write
    // cannot leak into a beat already accepted.
    logic signed [c_diff_w-1:0] w_data_x, w_mean_x, r_diff;
    logic signed [COEF_W-1:0]   r_inv1;
    logic signed [DATA_W-1:0]   r_raw1, r_raw2;
    logic [IDX_W-1:0]           r_idx1, r_idx2;
    logic                       r_v1, r_v2, r_last1, r_last2, r_byp1, r_byp2;

    assign w_data_x = {{(c_diff_w - DATA_W){bus.s_data[DATA_W-1]}}, bus.s_data};
    assign w_mean_x = {{(c_diff_w - COEF_W){r_mean[r_idx][COEF_W-1]}}, r_mean[r_idx]};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_v1 <= 1'b0; r_diff <= '0; r_inv1 <= '0; r_idx1 <= '0;
            r_last1 <= 1'b0; r_byp1 <= 1'b0; r_raw1 <= '0;
        end else if (w_en) begin
            r_v1    <= w_accept;
            r_diff  <= w_data_x - w_mean_x;
            r_inv1  <= r_inv[r_idx];
            r_idx1  <= r_idx;
            r_last1 <= bus.s_last;
            r_byp1  <= bus.bypass;
            r_raw1  <= bus.s_data;
        end
    end

    // Stage 2: full-precision product of sign-extended operands.
    logic signed [c_prod_w-1:0] w_diff_x, w_inv_x, r_prod;

    assign w_diff_x = {{COEF_W{r_diff[c_diff_w-1]}}, r_diff};
    assign w_inv_x  = {{c_diff_w{r_inv1[COEF_W-1]}}, r_inv1};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_v2 <= 1'b0; r_prod <= '0; r_idx2 <= '0;
            r_last2 <= 1'b0; r_byp2 <= 1'b0; r_raw2 <= '0;
        end else if (w_en) begin
            r_v2    <= r_v1;
            r_prod  <= w_diff_x * w_inv_x;
            r_idx2  <= r_idx1;
            r_last2 <= r_last1;
            r_byp2  <= r_byp1;
            r_raw2  <= r_raw1;
        end
    end

    // Stage 3: round half toward +inf, then clamp to the output range.
    logic signed [c_prod_w:0]   w_rnd, w_shift;
    logic signed [DATA_W-1:0]   w_sat, w_out;

    assign w_rnd   = {r_prod[c_prod_w-1], r_prod} + c_half;
    assign w_shift = w_rnd >>> FRAC_BITS;

    always_comb begin
        w_sat = w_shift[DATA_W-1:0];
        if (w_shift > c_max)      w_sat = c_max[DATA_W-1:0];
        else if (w_shift < c_min) w_sat = c_min[DATA_W-1:0];
    end

    assign w_out = r_byp2 ? r_raw2 : w_sat;

    logic                     r_m_valid, r_m_last;
    logic signed [DATA_W-1:0] r_m_data;
    logic [IDX_W-1:0]         r_m_index;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_m_valid <= 1'b0; r_m_data <= '0; r_m_last <= 1'b0; r_m_index <= '0;
        end else if (w_en) begin
            r_m_valid <= r_v2;
            r_m_data  <= w_out;
            r_m_last  <= r_last2;
            r_m_index <= r_idx2;
        end
    end

    assign bus.m_valid = r_m_valid;
    assign bus.m_data  = r_m_data;
    assign bus.m_last  = r_m_last;
    assign bus.m_index = r_m_index;
endmodule
`default_nettype wire

// File: tb/tb_feature_scaler_fx.sv
`default_nettype none
// ============================================================================
// Module   : tb_feature_scaler_fx
// Purpose  : Directed self-checking bench for feature_scaler_fx.
// Revision : 1.0
// ============================================================================
module tb_feature_scaler_fx;
    localparam int DATA_W    = 16;
    localparam int COEF_W    = 16;
    localparam int FRAC_BITS = 12;
    localparam int NUM_FEAT  = 39;
    localparam int IDX_W     = 6;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    feature_scaler_fx_if #(.DATA_W(DATA_W), .COEF_W(COEF_W), .IDX_W(IDX_W)) bus ();

    feature_scaler_fx #(
        .DATA_W(DATA_W), .COEF_W(COEF_W), .FRAC_BITS(FRAC_BITS),
        .NUM_FEAT(NUM_FEAT), .IDX_W(IDX_W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    typedef struct {
        string name;
        bit    do_cfg;
        int    mean;
        int    inv;
        int    k;
        int    data;
        bit    byp;
        int    expv;
    } vec_t;

    vec_t vecs[11];
    int   errors = 0;
    int   checks = 0;
    int   q_data[$];
    int   q_idx[$];
    bit   q_last[$];

    task automatic chk(input string name, input longint act, input longint expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    // Records every completed output handshake.
    always begin
        @(negedge clk);
        #2;
        if (reset === 1'b0 && bus.m_valid === 1'b1 && bus.m_ready === 1'b1) begin
            q_data.push_back(int'($signed(bus.m_data)));
            q_idx.push_back(int'(bus.m_index));
            q_last.push_back(bus.m_last);
        end
    end

    task automatic clear_q();
        q_data.delete(); q_idx.delete(); q_last.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; bus.s_valid = 1'b0; bus.s_last = 1'b0; bus.s_data = '0;
        bus.cfg_we = 1'b0; bus.cfg_sel = 1'b0; bus.cfg_addr = '0; bus.cfg_data = '0;
        bus.m_ready = 1'b1; bus.bypass = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        clear_q();
    endtask

    task automatic cfg_write(input bit sel, input int addr, input int val);
        @(negedge clk);
        bus.cfg_we = 1'b1; bus.cfg_sel = sel;
        bus.cfg_addr = IDX_W'(addr); bus.cfg_data = COEF_W'(val);
        @(posedge clk);
        #1 bus.cfg_we = 1'b0;
    endtask

    // Single beat with m_ready high, so the pipe always accepts it.
    task automatic push(input int data, input bit last, input bit byp, output bit err);
        @(negedge clk);
        bus.s_valid = 1'b1; bus.s_data = DATA_W'(data); bus.s_last = last; bus.bypass = byp;
        @(posedge clk);
        #1;
        bus.s_valid = 1'b0; bus.s_last = 1'b0; bus.bypass = 1'b0;
        err = bus.err_len;
    endtask

    task automatic wait_q(input int n, input string name);
        for (int c = 0; c < 20; c++) begin
            if (q_data.size() >= n) break;
            @(negedge clk);
            #3;
        end
        chk(name, q_data.size(), n);
    endtask

    initial begin
        bit  e;
        int  lat, i, cyc, stall_cnt, err_pulses, err_early;
        bit  prev_stall, held_last;
        int  held_data, held_idx;

        reset = 1'b1; bus.s_valid = 1'b0; bus.s_data = '0; bus.s_last = 1'b0;
        bus.m_ready = 1'b1; bus.cfg_we = 1'b0; bus.cfg_sel = 1'b0;
        bus.cfg_addr = '0; bus.cfg_data = '0; bus.bypass = 1'b0;

        vecs[0]  = '{"default",   1'b0,      0,  4096, 0,   1234, 1'b0,   1234};
        vecs[1]  = '{"scale2",    1'b1,    100,  8192, 0,    300, 1'b0,    400};
        vecs[2]  = '{"half_pos",  1'b1,      0,  2048, 1,      3, 1'b0,      2};
        vecs[3]  = '{"half_neg",  1'b1,      0,  2048, 1,     -3, 1'b0,     -1};
        vecs[4]  = '{"sat_hi",    1'b1, -32768,  4096, 0,  32767, 1'b0,  32767};
        vecs[5]  = '{"sat_lo",    1'b1,  32767,  4096, 0, -32768, 1'b0, -32768};
        vecs[6]  = '{"bypass",    1'b1,    100,  4096, 0,    300, 1'b1,    300};
        vecs[7]  = '{"rnd_p1",    1'b1,      0,  2048, 0,      1, 1'b0,      1};
        vecs[8]  = '{"rnd_m1",    1'b1,      0,  2048, 0,     -1, 1'b0,      0};
        vecs[9]  = '{"neg_inv",   1'b1,      0, -4096, 1,    500, 1'b0,   -500};
        vecs[10] = '{"big_gain",  1'b1,      0, 32767, 0,  32767, 1'b0,  32767};

        do_reset();
        #1;
        chk("rst m_valid", bus.m_valid, 0);
        chk("rst m_data", bus.m_data, 0);
        chk("rst m_index", bus.m_index, 0);
        chk("rst m_last", bus.m_last, 0);
        chk("rst err_len", bus.err_len, 0);
        chk("rst s_ready", bus.s_ready, 1);

        foreach (vecs[n]) begin
            do_reset();
            if (vecs[n].do_cfg) begin
                cfg_write(1'b0, vecs[n].k, vecs[n].mean);
                cfg_write(1'b1, vecs[n].k, vecs[n].inv);
            end
            if (vecs[n].k == 1) begin
                push(0, 1'b0, 1'b0, e);
                wait_q(1, {vecs[n].name, " lead"});
            end
            @(negedge clk);
            bus.s_valid = 1'b1; bus.s_data = DATA_W'(vecs[n].data);
            bus.s_last = 1'b0; bus.bypass = vecs[n].byp;
            @(posedge clk);
            #1;
            bus.s_valid = 1'b0; bus.bypass = 1'b0;
            lat = 1;
            while (!bus.m_valid && lat < 10) begin
                @(posedge clk);
                #1;
                lat++;
            end
            chk({vecs[n].name, " latency"}, lat, 3);
            chk({vecs[n].name, " data"}, int'($signed(bus.m_data)), vecs[n].expv);
            chk({vecs[n].name, " index"}, bus.m_index, vecs[n].k);
        end

        // Full frame with a 5-cycle output stall in the middle.
        do_reset();
        i = 0; cyc = 0; stall_cnt = 0; err_pulses = 0; prev_stall = 1'b0;
        held_data = 0; held_idx = 0; held_last = 1'b0;
        while ((i < NUM_FEAT || q_data.size() < NUM_FEAT) && cyc < 300) begin
            @(negedge clk);
            bus.m_ready = !(cyc >= 12 && cyc < 17);
            if (i < NUM_FEAT) begin
                bus.s_valid = 1'b1; bus.s_data = DATA_W'(i * 37 - 500);
                bus.s_last = (i == NUM_FEAT - 1);
            end else begin
                bus.s_valid = 1'b0; bus.s_last = 1'b0;
            end
            #1;
            if (bus.err_len) err_pulses++;
            if (prev_stall) begin
                chk("stall valid", bus.m_valid, 1);
                chk("stall data", int'($signed(bus.m_data)), held_data);
                chk("stall index", bus.m_index, held_idx);
                chk("stall last", bus.m_last, held_last);
            end
            prev_stall = bus.m_valid && !bus.m_ready;
            held_data  = int'($signed(bus.m_data));
            held_idx   = int'(bus.m_index);
            held_last  = bus.m_last;
            if (prev_stall) stall_cnt++;
            if (bus.s_valid && bus.s_ready) i++;
            cyc++;
        end
        bus.s_valid = 1'b0; bus.s_last = 1'b0; bus.m_ready = 1'b1;
        chk("bp accepted", i, NUM_FEAT);
        chk("bp outputs", q_data.size(), NUM_FEAT);
        chk("bp stall cycles", stall_cnt, 5);
        chk("bp err pulses", err_pulses, 0);
        for (int j = 0; j < NUM_FEAT && j < q_data.size(); j++) begin
            chk($sformatf("bp data %0d", j), q_data[j], j * 37 - 500);
            chk($sformatf("bp index %0d", j), q_idx[j], j);
            chk($sformatf("bp last %0d", j), q_last[j], (j == NUM_FEAT - 1) ? 1 : 0);
        end

        // Short frame: s_last on the 6th beat.
        do_reset();
        err_early = 0;
        for (int j = 0; j < 5; j++) begin
            push(10 + j, 1'b0, 1'b0, e);
            if (e) err_early++;
        end
        chk("short early err", err_early, 0);
        push(15, 1'b1, 1'b0, e);
        chk("short err pulse", e, 1);
        push(99, 1'b0, 1'b0, e);
        chk("short err cleared", e, 0);
        wait_q(7, "short outputs");
        chk("short last flag", q_last[5], 1);
        chk("short next index", q_idx[6], 0);
        chk("short next data", q_data[6], 99);

        // Long frame: 39 beats with no s_last.
        do_reset();
        err_early = 0;
        for (int j = 0; j < NUM_FEAT - 1; j++) begin
            push(j, 1'b0, 1'b0, e);
            if (e) err_early++;
        end
        chk("long early err", err_early, 0);
        push(NUM_FEAT - 1, 1'b0, 1'b0, e);
        chk("long err pulse", e, 1);
        push(777, 1'b0, 1'b0, e);
        chk("long err cleared", e, 0);
        wait_q(NUM_FEAT + 1, "long outputs");
        chk("long wrap index", q_idx[NUM_FEAT], 0);
        chk("long wrap last", q_last[NUM_FEAT - 1], 0);

        // cfg write colliding with acceptance at the same address.
        do_reset();
        cfg_write(1'b0, 0, 100);
        @(negedge clk);
        bus.s_valid = 1'b1; bus.s_data = DATA_W'(300); bus.s_last = 1'b1;
        bus.cfg_we = 1'b1; bus.cfg_sel = 1'b0; bus.cfg_addr = '0; bus.cfg_data = COEF_W'(50);
        @(posedge clk);
        #1;
        bus.s_valid = 1'b0; bus.s_last = 1'b0; bus.cfg_we = 1'b0;
        push(300, 1'b1, 1'b0, e);
        wait_q(2, "collide outputs");
        chk("collide old mean", q_data[0], 200);
        chk("collide new mean", q_data[1], 250);

        // Reset mid-stream drops in-flight beats.
        do_reset();
        push(11, 1'b0, 1'b0, e);
        push(22, 1'b0, 1'b0, e);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midrst m_valid", bus.m_valid, 0);
        chk("midrst m_index", bus.m_index, 0);
        chk("midrst m_data", bus.m_data, 0);
        repeat (5) @(negedge clk);
        #3;
        chk("midrst no output", q_data.size(), 0);
        push(7, 1'b0, 1'b0, e);
        wait_q(1, "midrst outputs");
        chk("midrst first index", q_idx[0], 0);
        chk("midrst first data", q_data[0], 7);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
`default_nettype wire
